// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game control path.
package simon_pkg;

  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned SEQ_W   = 64;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2,
    BLUE   = 2'd3
  } color_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    OK,
    FAIL
  } in_state_t;

  // Only meaningful for a one-hot input; anything else maps to GREEN.
  function automatic color_t onehot_to_color(input logic [3:0] oh);
    color_t c;
    case (oh)
      4'b0010: c = YELLOW;
      4'b0100: c = RED;
      4'b1000: c = BLUE;
      default: c = GREEN;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] color_to_onehot(input color_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/simon_press_timer.sv
// Idle-cycle counter between button presses; flags when the allowed window is used up.
module simon_press_timer #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (clr)   count <= '0;
    else if (en)    count <= count + W'(1);
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/simon_input_handler.sv
// Captures player presses, packs them into user_seq and reports the round result.
module simon_input_handler #(
  parameter int unsigned MAX_LEN     = 32,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  btn,
  input  logic [63:0] exp_seq,
  input  logic [5:0]  seq_len,
  output logic [3:0]  incolor,
  output logic [63:0] user_seq,
  output logic [5:0]  user_pos,
  output logic        score_update,
  output logic        round_ok,
  output logic        round_fail,
  output logic        busy
);

  import simon_pkg::*;

  in_state_t   state_q, state_d;
  logic [5:0]  len_q, len_d, clamp_len, user_pos_d, pos_inc;
  logic        err_q, err_d;
  logic [3:0]  incolor_d;
  logic [63:0] user_seq_d;
  logic [5:0]  slot;
  color_t      press_c, exp_c;
  logic        tmr_clr, tmr_en, tmr_expired;

  simon_press_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  assign slot    = {user_pos[4:0], 1'b0};
  assign press_c = onehot_to_color(btn);
  assign exp_c   = color_t'(exp_seq[slot +: 2]);
  assign pos_inc = user_pos + 6'd1;

  always_comb begin
    clamp_len = seq_len;
    if (seq_len == 6'd0)             clamp_len = 6'd1;
    else if (32'(seq_len) > MAX_LEN) clamp_len = 6'(MAX_LEN);
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    err_d      = err_q;
    incolor_d  = incolor;
    user_seq_d = user_seq;
    user_pos_d = user_pos;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (start) begin
          user_seq_d = '0;
          user_pos_d = '0;
          len_d      = clamp_len;
          err_d      = 1'b0;
          state_d    = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if ($onehot(btn)) begin
          user_seq_d[slot +: 2] = press_c;
          incolor_d             = color_to_onehot(press_c);
          err_d                 = (press_c != exp_c);
          tmr_clr               = 1'b1;
          state_d               = WAIT_RELEASE;
        end else if (tmr_expired) begin
          state_d = FAIL;
        end else begin
          tmr_en = 1'b1;
        end
      end
      WAIT_RELEASE: begin
        // A wrong color is only reported once the button is let go.
        if (btn == 4'b0000) begin
          incolor_d = '0;
          if (err_q) begin
            state_d = FAIL;
          end else begin
            user_pos_d = pos_inc;
            state_d    = (pos_inc == len_q) ? OK : WAIT_PRESS;
          end
        end
      end
      OK:      state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      err_q    <= 1'b0;
      incolor  <= '0;
      user_seq <= '0;
      user_pos <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      err_q    <= err_d;
      incolor  <= incolor_d;
      user_seq <= user_seq_d;
      user_pos <= user_pos_d;
    end
  end

  assign round_ok     = (state_q == OK);
  assign score_update = (state_q == OK);
  assign round_fail   = (state_q == FAIL);
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_simon_input_handler.sv
// Directed bench for simon_input_handler with a short timeout window.
module tb_simon_input_handler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  btn = '0;
  logic [63:0] exp_seq = '0;
  logic [5:0]  seq_len = '0;
  logic [3:0]  incolor;
  logic [63:0] user_seq;
  logic [5:0]  user_pos;
  logic        score_update, round_ok, round_fail, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int ok_cnt   = 0;
  int fail_cnt = 0;
  int su_cnt   = 0;

  simon_input_handler #(.MAX_LEN(32), .TIMEOUT_CYC(20)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .btn          (btn),
    .exp_seq      (exp_seq),
    .seq_len      (seq_len),
    .incolor      (incolor),
    .user_seq     (user_seq),
    .user_pos     (user_pos),
    .score_update (score_update),
    .round_ok     (round_ok),
    .round_fail   (round_fail),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (round_ok)     ok_cnt   <= ok_cnt + 1;
    if (round_fail)   fail_cnt <= fail_cnt + 1;
    if (score_update) su_cnt   <= su_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_round(input logic [5:0] len, input logic [63:0] exp);
    seq_len = len;
    exp_seq = exp;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    tick();
    check("incolor_press", {60'd0, incolor}, {60'd0, b});
    btn = 4'b0000;
    tick();
    check("incolor_release", {60'd0, incolor}, 64'd0);
  endtask

  int ok0, fail0, su0;
  logic [63:0] long_exp;
  logic [1:0]  c;

  initial begin
    // Reset state
    tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_incolor", {60'd0, incolor}, 64'd0);
    check("rst_user_seq", user_seq, 64'd0);
    check("rst_user_pos", {58'd0, user_pos}, 64'd0);
    check("rst_ok", {63'd0, round_ok}, 64'd0);
    check("rst_fail", {63'd0, round_fail}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Correct 3-color round: G, Y, R
    open_round(6'd3, 64'h24);
    check("t1_busy", {63'd0, busy}, 64'd1);
    press(4'b0001);
    press(4'b0010);
    check("t1_pos2", {58'd0, user_pos}, 64'd2);
    press(4'b0100);
    check("t1_ok_pulse", {63'd0, round_ok}, 64'd1);
    check("t1_su_pulse", {63'd0, score_update}, 64'd1);
    check("t1_pos", {58'd0, user_pos}, 64'd3);
    check("t1_seq", user_seq, 64'h24);
    tick();
    check("t1_ok_drop", {63'd0, round_ok}, 64'd0);
    check("t1_busy_drop", {63'd0, busy}, 64'd0);
    check("t1_ok_cnt", 64'(ok_cnt), 64'd1);
    check("t1_su_cnt", 64'(su_cnt), 64'd1);

    // Wrong second color: expected G, Y; pressed G, B
    open_round(6'd2, 64'h4);
    check("t2_seq_clr", user_seq, 64'd0);
    check("t2_pos_clr", {58'd0, user_pos}, 64'd0);
    press(4'b0001);
    btn = 4'b1000;
    tick();
    check("t2_no_fail_at_press", {63'd0, round_fail}, 64'd0);
    btn = 4'b0000;
    tick();
    check("t2_fail_pulse", {63'd0, round_fail}, 64'd1);
    check("t2_pos", {58'd0, user_pos}, 64'd1);
    check("t2_slot1", {62'd0, user_seq[3:2]}, 64'd3);
    tick();
    check("t2_su_cnt", 64'(su_cnt), 64'd1);
    check("t2_fail_cnt", 64'(fail_cnt), 64'd1);

    // Timeout: fail exactly 20 cycles after entering WAIT_PRESS
    open_round(6'd1, 64'h0);
    repeat (19) tick();
    check("t3_no_fail_19", {63'd0, round_fail}, 64'd0);
    check("t3_busy_19", {63'd0, busy}, 64'd1);
    tick();
    check("t3_fail_20", {63'd0, round_fail}, 64'd1);
    tick();
    check("t3_fail_cnt", 64'(fail_cnt), 64'd2);

    // Multi-hot ignored, held/changed button ignored, busy start ignored
    open_round(6'd1, 64'h0);
    btn = 4'b0011;
    repeat (5) tick();
    check("t4_multi_incolor", {60'd0, incolor}, 64'd0);
    check("t4_multi_seq", user_seq, 64'd0);
    btn = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      tick();
    end
    start = 1'b0;
    check("t4_held_incolor", {60'd0, incolor}, 64'd1);
    check("t4_held_pos", {58'd0, user_pos}, 64'd0);
    btn = 4'b0100;
    repeat (2) tick();
    check("t4_change_incolor", {60'd0, incolor}, 64'd1);
    btn = 4'b0000;
    tick();
    check("t4_ok_pulse", {63'd0, round_ok}, 64'd1);
    check("t4_pos", {58'd0, user_pos}, 64'd1);
    check("t4_seq", user_seq, 64'd0);
    tick();
    check("t4_idle", {63'd0, busy}, 64'd0);
    check("t4_ok_cnt", 64'(ok_cnt), 64'd2);

    // seq_len = 0 clamps to one press
    open_round(6'd0, 64'h0);
    press(4'b0001);
    check("t5a_ok_pulse", {63'd0, round_ok}, 64'd1);
    check("t5a_pos", {58'd0, user_pos}, 64'd1);
    tick();

    // seq_len = 40 clamps to 32 presses
    long_exp = 64'hE4E4_1B1B_D8D8_2727;
    open_round(6'd40, long_exp);
    for (int i = 0; i < 32; i++) begin
      c   = long_exp[2*i +: 2];
      btn = 4'b0001 << c;
      tick();
      btn = 4'b0000;
      tick();
      if (i == 30) begin
        check("t5b_pos31", {58'd0, user_pos}, 64'd31);
        check("t5b_no_early_ok", {63'd0, round_ok}, 64'd0);
      end
    end
    check("t5b_ok_pulse", {63'd0, round_ok}, 64'd1);
    check("t5b_pos", {58'd0, user_pos}, 64'd32);
    check("t5b_seq", user_seq, long_exp);
    tick();

    // Reset mid-round after two correct presses
    open_round(6'd4, 64'hE4);
    press(4'b0001);
    press(4'b0010);
    btn = 4'b0100;
    tick();
    ok0 = ok_cnt; fail0 = fail_cnt; su0 = su_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", {63'd0, busy}, 64'd0);
    check("t6_incolor", {60'd0, incolor}, 64'd0);
    check("t6_pos", {58'd0, user_pos}, 64'd0);
    check("t6_seq", user_seq, 64'd0);
    btn = 4'b0000;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t6_no_ok", 64'(ok_cnt), 64'(ok0));
    check("t6_no_fail", 64'(fail_cnt), 64'(fail0));
    check("t6_no_su", 64'(su_cnt), 64'(su0));
    check("t6_idle", {63'd0, busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
